// File: rtl/pipe_hazard_scoreboard.sv
// ============================================================================
//  Module      : pipe_hazard_scoreboard
//  Description : In-flight register-write scoreboard; raises stall on RAW hazards.
//                Optional macro HZ_WB_BYPASS_EN excludes the WB entry from stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_scoreboard #(
    parameter int AW           = 5,
    parameter int WPORTS       = 2,
    parameter int RPORTS       = 2,
    parameter int DEPTH        = 3,
    parameter int COND_STAGE   = 0,
    parameter int FLUSH_STAGES = 1,
    parameter int CW           = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [WPORTS*AW-1:0]   issue_wa,
    input  logic [WPORTS-1:0]      issue_we,
    input  logic [RPORTS*AW-1:0]   rd_a,
    input  logic [RPORTS-1:0]      rd_en,
    input  logic                   cond_fail,
    input  logic                   flush,
    output logic                   stall,
    output logic [DEPTH-1:0]       hz_stage,
    output logic                   issue_ack,
    output logic [CW-1:0]          stall_cnt
);

`ifdef HZ_WB_BYPASS_EN
    localparam logic [DEPTH-1:0] c_stall_mask = ~(DEPTH'(1) << (DEPTH-1));
`else
    localparam logic [DEPTH-1:0] c_stall_mask = '1;
`endif

    logic [DEPTH-1:0]                 v_q, v_d;
    logic [DEPTH-1:0][WPORTS*AW-1:0]  wa_q, wa_d;
    logic [DEPTH-1:0][WPORTS-1:0]     we_q, we_d;
    logic [CW-1:0]                    stall_cnt_q, stall_cnt_d;
    logic [DEPTH-1:0]                 w_hz;

    always_comb begin
        w_hz = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < RPORTS; j++) begin
                for (int k = 0; k < WPORTS; k++) begin
                    if (rd_en[j] && v_q[i] && we_q[i][k] &&
                        (wa_q[i][k*AW +: AW] == rd_a[j*AW +: AW])) begin
                        w_hz[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign hz_stage  = w_hz;
    assign stall     = |(w_hz & c_stall_mask);
    assign issue_ack = issue_valid && !stall && !flush;
    assign stall_cnt = stall_cnt_q;

    // Flush squashes the youngest entries before the shift; cond_fail only
    // strips the write enables of the entry leaving COND_STAGE.
    always_comb begin
        v_d  = '0;
        wa_d = '0;
        we_d = '0;
        for (int i = 0; i < DEPTH-1; i++) begin
            v_d[i+1]  = v_q[i] && !(flush && (i < FLUSH_STAGES));
            wa_d[i+1] = wa_q[i];
            if ((flush && (i < FLUSH_STAGES)) || (cond_fail && (i == COND_STAGE))) begin
                we_d[i+1] = '0;
            end else begin
                we_d[i+1] = we_q[i];
            end
        end
        if (issue_ack) begin
            v_d[0]  = 1'b1;
            wa_d[0] = issue_wa;
            we_d[0] = issue_we;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q         <= '0;
            wa_q        <= '0;
            we_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wa_q        <= wa_d;
            we_q        <= we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
// ============================================================================
//  Module      : tb_pipe_hazard_scoreboard
//  Description : Self-checking bench for pipe_hazard_scoreboard (CW=4 build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_scoreboard;

    localparam int AW           = 5;
    localparam int WPORTS       = 2;
    localparam int RPORTS       = 2;
    localparam int DEPTH        = 3;
    localparam int COND_STAGE   = 0;
    localparam int FLUSH_STAGES = 1;
    localparam int CW           = 4;
    localparam int CNT_MAX      = (1 << CW) - 1;
`ifdef HZ_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic [WPORTS*AW-1:0]  issue_wa;
    logic [WPORTS-1:0]     issue_we;
    logic [RPORTS*AW-1:0]  rd_a;
    logic [RPORTS-1:0]     rd_en;
    logic                  cond_fail;
    logic                  flush;
    logic                  stall;
    logic [DEPTH-1:0]      hz_stage;
    logic                  issue_ack;
    logic [CW-1:0]         stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_scoreboard #(
        .AW(AW), .WPORTS(WPORTS), .RPORTS(RPORTS), .DEPTH(DEPTH),
        .COND_STAGE(COND_STAGE), .FLUSH_STAGES(FLUSH_STAGES), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wa(issue_wa),
        .issue_we(issue_we), .rd_a(rd_a), .rd_en(rd_en), .cond_fail(cond_fail),
        .flush(flush), .stall(stall), .hz_stage(hz_stage), .issue_ack(issue_ack),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a flat list of pending register writes, each with its age.
    typedef struct {
        logic [AW-1:0] a;
        int            age;
    } pw_t;
    pw_t pend[$];
    int  m_cnt = 0;

    function automatic logic [DEPTH-1:0] m_hz();
        logic [DEPTH-1:0] h = '0;
        foreach (pend[n]) begin
            for (int j = 0; j < RPORTS; j++) begin
                if (rd_en[j] && (rd_a[j*AW +: AW] == pend[n].a)) h[pend[n].age] = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic m_stall();
        logic [DEPTH-1:0] h = m_hz();
        if (BYP) h[DEPTH-1] = 1'b0;
        return |h;
    endfunction

    function automatic logic m_ack();
        return issue_valid && !m_stall() && !flush;
    endfunction

    task automatic tick();
        logic st, ak;
        pw_t  nq[$];
        pw_t  p;
        st = m_stall();
        ak = m_ack();
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            m_cnt = 0;
        end else begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            foreach (pend[n]) begin
                p = pend[n];
                if (flush && p.age < FLUSH_STAGES) continue;
                if (cond_fail && p.age == COND_STAGE) continue;
                p.age++;
                if (p.age < DEPTH) nq.push_back(p);
            end
            if (ak) begin
                for (int k = 0; k < WPORTS; k++) begin
                    if (issue_we[k]) nq.push_back('{issue_wa[k*AW +: AW], 0});
                end
            end
            pend = nq;
        end
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_wa = '0; issue_we = '0;
        rd_a = '0; rd_en = '0; cond_fail = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            issue_valid = 1'b1; issue_we = 2'b11;
            issue_wa = {5'd2, 5'd1}; rd_a = {5'd2, 5'd1}; rd_en = 2'b11;
            tick();
        end
        rst = 1'b0;
        issue_valid = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (hz_stage !== '0 || stall !== 1'b0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: hz=%b stall=%b cnt=%0d required hz=000 stall=0 cnt=0", hz_stage, stall, stall_cnt);
        end
        n_checks++;
        if (issue_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ack: issue_ack=%b required 1", issue_ack);
        end
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1'b1; issue_we = 2'b01; issue_wa = {5'd0, 5'd5};
        tick();
        idle_inputs();
        rd_a = {5'd0, 5'd5}; rd_en = 2'b01;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_checks++;
            if (hz_stage !== 3'(1 << c) || stall !== ((c < DEPTH-1) || !BYP)) begin
                n_fail++;
                $display("FAIL raw_c%0d: hz=%b stall=%b required hz=%b stall=%b", c, hz_stage, stall,
                         3'(1 << c), ((c < DEPTH-1) || !BYP));
            end
            tick();
        end
        #1;
        n_checks++;
        if (hz_stage !== '0 || stall !== 1'b0 || stall_cnt !== (BYP ? 4'd2 : 4'd3)) begin
            n_fail++;
            $display("FAIL raw_done: hz=%b stall=%b cnt=%0d required 000/0/%0d", hz_stage, stall, stall_cnt,
                     BYP ? 2 : 3);
        end
    endtask

    task automatic test_dual_write();
        do_reset();
        issue_valid = 1'b1; issue_we = 2'b11; issue_wa = {5'd9, 5'd7};
        tick();
        idle_inputs();
        rd_a = {5'd7, 5'd9}; rd_en = 2'b11;
        #1;
        n_checks++;
        if (hz_stage !== 3'b001 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_hit: hz=%b stall=%b required 001/1", hz_stage, stall);
        end
        rd_a = {5'd3, 5'd4};
        #1;
        n_checks++;
        if (hz_stage !== 3'b000 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_miss: hz=%b stall=%b required 000/0", hz_stage, stall);
        end
        tick();
    endtask

    task automatic test_cond_cancel();
        do_reset();
        issue_valid = 1'b1; issue_we = 2'b01; issue_wa = {5'd0, 5'd12};
        tick();
        idle_inputs();
        rd_a = {5'd0, 5'd12}; rd_en = 2'b01; cond_fail = 1'b1;
        #1;
        n_checks++;
        if (hz_stage !== 3'b001 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL cond_before: hz=%b stall=%b required 001/1", hz_stage, stall);
        end
        tick();
        cond_fail = 1'b0;
        #1;
        n_checks++;
        if (hz_stage !== 3'b000 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL cond_after: hz=%b stall=%b required 000/0", hz_stage, stall);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issue_valid = 1'b1; issue_we = 2'b01; issue_wa = {5'd0, 5'd10};
        tick();
        issue_wa = {5'd0, 5'd6};
        tick();
        issue_wa = {5'd0, 5'd6}; flush = 1'b1;
        #1;
        n_checks++;
        if (issue_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ack: issue_ack=%b required 0", issue_ack);
        end
        tick();
        idle_inputs();
        rd_a = {5'd10, 5'd6}; rd_en = 2'b11;
        #1;
        n_checks++;
        if (hz_stage !== 3'b100 || stall !== !BYP) begin
            n_fail++;
            $display("FAIL flush_after: hz=%b stall=%b required 100/%b", hz_stage, stall, !BYP);
        end
        rd_en = 2'b01;
        #1;
        n_checks++;
        if (hz_stage !== 3'b000 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_squash: hz=%b stall=%b required 000/0", hz_stage, stall);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        issue_valid = 1'b1; issue_we = 2'b01; issue_wa = {5'd0, 5'd3};
        rd_a = {5'd0, 5'd3}; rd_en = 2'b01;
        for (int c = 0; c < 40; c++) begin
            #1;
            n_checks++;
            if (stall_cnt !== CW'(m_cnt) || stall !== m_stall()) begin
                n_fail++;
                $display("FAIL sat_c%0d: cnt=%0d stall=%b required %0d/%b", c, stall_cnt, stall, m_cnt, m_stall());
            end
            tick();
        end
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d required 15", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 50) != 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_we    = WPORTS'($urandom_range(0, 3));
            for (int k = 0; k < WPORTS; k++) issue_wa[k*AW +: AW] = AW'($urandom_range(0, 7));
            for (int j = 0; j < RPORTS; j++) rd_a[j*AW +: AW] = AW'($urandom_range(0, 7));
            rd_en       = RPORTS'($urandom_range(0, 3));
            cond_fail   = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            #1;
            n_checks++;
            if (hz_stage !== m_hz() || stall !== m_stall() || issue_ack !== m_ack() || stall_cnt !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_c%0d: hz=%b stall=%b ack=%b cnt=%0d required hz=%b stall=%b ack=%b cnt=%0d",
                         c, hz_stage, stall, issue_ack, stall_cnt, m_hz(), m_stall(), m_ack(), m_cnt);
            end
            tick();
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        test_reset();
        test_raw();
        test_dual_write();
        test_cond_cancel();
        test_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
